// File: rtl/ppg_pkg.sv
// Shared types for the PPG front-end chain: LED phase, sampler state and ADC width.
// Imported by the calibration controller, this sampler and the FIR stage.
package ppg_pkg;

  localparam int ADC_W = 8;

  typedef enum logic [1:0] {
    PH_NONE = 2'd0,
    PH_RED  = 2'd1,
    PH_IR   = 2'd2
  } phase_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACCUM  = 2'd2,
    ST_HOLD   = 2'd3
  } smp_state_t;

  // Exactly one LED lit selects a channel; both or neither means no valid phase.
  function automatic phase_t decode_phase(input logic red, input logic ir);
    if (red && !ir) return PH_RED;
    if (ir && !red) return PH_IR;
    return PH_NONE;
  endfunction

endpackage

// File: rtl/ppg_slot_accum.sv
// Per-slot accumulator: sums 2^AVG_LOG2 accepted samples and presents the truncated
// average combinationally alongside a done strobe on the final sample.
module ppg_slot_accum
  import ppg_pkg::*;
#(
  parameter int W        = ADC_W,
  parameter int AVG_LOG2 = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clear,
  input  logic         i_sample,
  input  logic [W-1:0] i_adc,
  output logic         o_done,
  output logic [W-1:0] o_avg
);

  localparam int         AW   = W + AVG_LOG2;
  localparam logic [6:0] LAST = 7'((1 << AVG_LOG2) - 1);

  logic [AW-1:0] r_acc;
  logic [6:0]    r_cnt;
  logic [AW-1:0] w_sum;

  // The final sample is folded in here so the average is ready in its own cycle.
  assign w_sum  = r_acc + AW'(i_adc);
  assign o_done = i_sample && (r_cnt == LAST);
  assign o_avg  = W'(w_sum >> AVG_LOG2);

  // NOTE: non-blocking assignments so acc and cnt both update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || i_clear || o_done) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_sample) begin
      r_acc <= w_sum;
      r_cnt <= r_cnt + 7'd1;
    end
  end

endmodule

// File: rtl/ppg_channel_sampler.sv
// Splits the shared photodiode ADC stream into averaged red/IR samples, skipping
// settling conversions after each LED switch, and hands out pairs on valid/ready.
module ppg_channel_sampler
  import ppg_pkg::*;
#(
  parameter int W              = ADC_W,
  parameter int SETTLE_SAMPLES = 4,
  parameter int AVG_LOG2       = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_adc,
  input  logic         i_adc_valid,
  input  logic         i_led_red,
  input  logic         i_led_ir,
  input  logic         i_cal_done,
  input  logic         i_ovr_clr,
  output logic [W-1:0] o_out_red,
  output logic [W-1:0] o_out_ir,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic         o_overrun
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_SAMPLES - 1);

  phase_t     w_phase, r_phase_q;
  smp_state_t r_state;
  logic [7:0] r_settle_cnt;
  logic       r_red_have, r_ir_have;
  logic [W-1:0] r_red_avg, r_ir_avg;

  logic         w_change, w_force_idle, w_sample, w_clear, w_done;
  logic         w_red_done, w_ir_done, w_red_have, w_ir_have, w_pair;
  logic [W-1:0] w_avg, w_red_avg, w_ir_avg;

  assign w_phase      = decode_phase(i_led_red, i_led_ir);
  assign w_change     = (w_phase != r_phase_q);
  assign w_force_idle = !i_cal_done || (w_phase == PH_NONE);

  // A strobe arriving with a phase change belongs to the old LED and is dropped.
  assign w_sample = (r_state == ST_ACCUM) && i_adc_valid && !w_change && !w_force_idle;
  assign w_clear  = (r_state != ST_ACCUM) || w_change || w_force_idle;

  ppg_slot_accum #(.W(W), .AVG_LOG2(AVG_LOG2)) u_accum (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_clear),
    .i_sample(w_sample),
    .i_adc   (i_adc),
    .o_done  (w_done),
    .o_avg   (w_avg)
  );

  assign w_red_done = w_done && (r_phase_q == PH_RED);
  assign w_ir_done  = w_done && (r_phase_q == PH_IR);
  assign w_red_have = r_red_have || w_red_done;
  assign w_ir_have  = r_ir_have  || w_ir_done;
  assign w_red_avg  = w_red_done ? w_avg : r_red_avg;
  assign w_ir_avg   = w_ir_done  ? w_avg : r_ir_avg;
  assign w_pair     = w_red_have && w_ir_have;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_phase_q    <= PH_NONE;
      r_state      <= ST_IDLE;
      r_settle_cnt <= '0;
      r_red_have   <= 1'b0;
      r_ir_have    <= 1'b0;
      r_red_avg    <= '0;
      r_ir_avg     <= '0;
    end else begin
      r_phase_q <= w_phase;
      if (w_force_idle) begin
        r_state      <= ST_IDLE;
        r_settle_cnt <= '0;
        r_red_have   <= 1'b0;
        r_ir_have    <= 1'b0;
      end else begin
        // Have-flags survive RED<->IR switches; only a full pair consumes them.
        r_red_have <= w_red_have && !w_pair;
        r_ir_have  <= w_ir_have  && !w_pair;
        r_red_avg  <= w_red_avg;
        r_ir_avg   <= w_ir_avg;
        if (r_state == ST_IDLE || w_change) begin
          r_state      <= ST_SETTLE;
          r_settle_cnt <= '0;
        end else begin
          case (r_state)
            ST_SETTLE: if (i_adc_valid) begin
              if (r_settle_cnt == SETTLE_LAST) begin
                r_state      <= ST_ACCUM;
                r_settle_cnt <= '0;
              end else begin
                r_settle_cnt <= r_settle_cnt + 8'd1;
              end
            end
            ST_ACCUM: if (w_done) r_state <= ST_HOLD;
            default: ;
          endcase
        end
      end
    end
  end

  // Output stage keeps running through IDLE so a pending pair can still drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_out_red   <= '0;
      o_out_ir    <= '0;
      o_out_valid <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      if (w_pair && (!o_out_valid || i_out_ready)) begin
        o_out_red   <= w_red_avg;
        o_out_ir    <= w_ir_avg;
        o_out_valid <= 1'b1;
      end else if (o_out_valid && i_out_ready) begin
        o_out_valid <= 1'b0;
      end
      if (w_pair && o_out_valid && !i_out_ready) o_overrun <= 1'b1;
      else if (i_ovr_clr)                         o_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ppg_channel_sampler.sv
// Checks two sampler configurations cycle by cycle against a segment-level model of
// the red/IR slot averaging and pair handshake, with directed and random LED sequences.
module tb_ppg_channel_sampler;
  import ppg_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, adc_valid, led_red, led_ir, cal_done, ovr_clr, out_ready;
  logic [7:0] adc;
  logic [7:0] a_red, a_ir, b_red, b_ir;
  logic       a_valid, a_ovr, b_valid, b_ovr;

  ppg_channel_sampler #(.W(8), .SETTLE_SAMPLES(4), .AVG_LOG2(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_adc(adc), .i_adc_valid(adc_valid),
    .i_led_red(led_red), .i_led_ir(led_ir), .i_cal_done(cal_done), .i_ovr_clr(ovr_clr),
    .o_out_red(a_red), .o_out_ir(a_ir), .o_out_valid(a_valid), .i_out_ready(out_ready),
    .o_overrun(a_ovr)
  );

  ppg_channel_sampler #(.W(8), .SETTLE_SAMPLES(1), .AVG_LOG2(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_adc(adc), .i_adc_valid(adc_valid),
    .i_led_red(led_red), .i_led_ir(led_ir), .i_cal_done(cal_done), .i_ovr_clr(ovr_clr),
    .o_out_red(b_red), .o_out_ir(b_ir), .o_out_valid(b_valid), .i_out_ready(out_ready),
    .o_overrun(b_ovr)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model: each uninterrupted stretch of one lit LED is a segment; strobes 1..SETTLE
  // are skipped, the next N are averaged, anything later is ignored.
  int unsigned settle_n[2] = '{4, 1};
  int unsigned avg_n[2]    = '{4, 1};
  bit          seg_on[2];
  phase_t      prev_ph[2];
  int unsigned strobes[2], taken[2], sum[2];
  bit          have_r[2], have_i[2];
  int unsigned avg_r[2], avg_i[2];
  bit          m_valid[2], m_ovr[2];
  int unsigned m_red[2], m_ir[2];

  task automatic model_reset(input int k);
    seg_on[k] = 0; prev_ph[k] = PH_NONE; strobes[k] = 0; taken[k] = 0; sum[k] = 0;
    have_r[k] = 0; have_i[k] = 0; avg_r[k] = 0; avg_i[k] = 0;
    m_valid[k] = 0; m_ovr[k] = 0; m_red[k] = 0; m_ir[k] = 0;
  endtask

  task automatic model_step(input int k);
    phase_t ph;
    bit     drop;
    ph = (led_red && !led_ir) ? PH_RED : (led_ir && !led_red) ? PH_IR : PH_NONE;
    if (!rst_n) begin
      model_reset(k);
      return;
    end
    if (!cal_done || ph == PH_NONE) begin
      seg_on[k] = 0; have_r[k] = 0; have_i[k] = 0;
    end else if (!seg_on[k] || ph != prev_ph[k]) begin
      seg_on[k] = 1; strobes[k] = 0; taken[k] = 0; sum[k] = 0;
    end else if (adc_valid) begin
      strobes[k]++;
      if (strobes[k] > settle_n[k] && taken[k] < avg_n[k]) begin
        sum[k] += adc;
        taken[k]++;
        if (taken[k] == avg_n[k]) begin
          if (ph == PH_RED) begin avg_r[k] = sum[k] / avg_n[k]; have_r[k] = 1; end
          else              begin avg_i[k] = sum[k] / avg_n[k]; have_i[k] = 1; end
        end
      end
    end
    prev_ph[k] = ph;
    drop = 0;
    if (have_r[k] && have_i[k]) begin
      have_r[k] = 0; have_i[k] = 0;
      if (!m_valid[k] || out_ready) begin
        m_red[k] = avg_r[k]; m_ir[k] = avg_i[k]; m_valid[k] = 1;
      end else begin
        drop = 1;
      end
    end else if (m_valid[k] && out_ready) begin
      m_valid[k] = 0;
    end
    if (drop) m_ovr[k] = 1;
    else if (ovr_clr) m_ovr[k] = 0;
  endtask

  task automatic compare();
    check("a_red", a_red, m_red[0]);   check("a_ir", a_ir, m_ir[0]);
    check("a_valid", a_valid, m_valid[0]); check("a_ovr", a_ovr, m_ovr[0]);
    check("b_red", b_red, m_red[1]);   check("b_ir", b_ir, m_ir[1]);
    check("b_valid", b_valid, m_valid[1]); check("b_ovr", b_ovr, m_ovr[1]);
  endtask

  // Called at a negedge: drive, let one rising edge pass, then compare at the next negedge.
  task automatic drive(input bit rn, input bit cal, input bit red, input bit ir, input bit vld,
                       input logic [7:0] a, input bit rdy, input bit clr);
    rst_n = rn; cal_done = cal; led_red = red; led_ir = ir;
    adc_valid = vld; adc = a; out_ready = rdy; ovr_clr = clr;
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    compare();
  endtask

  // One LED-switch cycle without a strobe, then n strobes from v.
  task automatic feed(input bit red, input bit ir, input int v[8], input int n,
                      input bit rdy, input bit rdy_last);
    drive(1, 1, red, ir, 0, 8'd0, rdy, 0);
    for (int i = 0; i < n; i++)
      drive(1, 1, red, ir, 1, 8'(v[i]), (i == n - 1) ? rdy_last : rdy, 0);
  endtask

  initial begin
    phase_t rnd_ph;
    rst_n = 0; cal_done = 0; led_red = 0; led_ir = 0;
    adc_valid = 0; adc = 0; out_ready = 1; ovr_clr = 0;
    model_reset(0);
    model_reset(1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", a_valid, 0); check("rst_red", a_red, 0);
    check("rst_ir", a_ir, 0);       check("rst_ovr", a_ovr, 0);

    // Basic pair and settle skipping
    feed(1, 0, '{255, 255, 255, 255, 10, 20, 30, 41}, 8, 1, 1);
    feed(0, 1, '{255, 255, 255, 255, 200, 200, 200, 200}, 8, 1, 1);
    check("basic_valid", a_valid, 1); check("basic_red", a_red, 25); check("basic_ir", a_ir, 200);

    // Truncation, and single-sample averaging in the AVG_LOG2=0 instance
    feed(1, 0, '{255, 255, 255, 255, 1, 1, 1, 2}, 8, 1, 1);
    feed(0, 1, '{255, 77, 255, 255, 0, 0, 0, 3}, 8, 1, 1);
    check("trunc_red", a_red, 1); check("trunc_ir", a_ir, 0);
    check("avg1_ir", b_ir, 77);   check("avg1_red", b_red, 255);

    // Mid-slot switch discards the partial red slot
    feed(1, 0, '{255, 255, 255, 255, 100, 100, 0, 0}, 6, 1, 1);
    feed(0, 1, '{255, 255, 255, 255, 60, 60, 60, 60}, 8, 1, 1);
    feed(1, 0, '{255, 255, 255, 255, 8, 8, 8, 8}, 8, 1, 1);
    check("switch_red", a_red, 8); check("switch_ir", a_ir, 60);

    // Backpressure: second pair dropped, first held, overrun sticky until cleared
    feed(0, 1, '{255, 255, 255, 255, 50, 50, 50, 50}, 8, 0, 0);
    feed(1, 0, '{255, 255, 255, 255, 70, 70, 70, 70}, 8, 0, 0);
    check("bp_ovr", a_ovr, 1); check("bp_red", a_red, 8);
    check("bp_ir", a_ir, 60);  check("bp_valid", a_valid, 1);
    drive(1, 1, 1, 0, 0, 8'd0, 0, 1);
    check("ovr_clr", a_ovr, 0);
    feed(0, 1, '{255, 255, 255, 255, 90, 90, 90, 90}, 8, 0, 0);
    feed(1, 0, '{255, 255, 255, 255, 33, 33, 33, 33}, 8, 0, 1);
    check("accept_load_valid", a_valid, 1); check("accept_load_red", a_red, 33);
    check("accept_load_ir", a_ir, 90);      check("accept_load_ovr", a_ovr, 0);

    // Both LEDs mid-ACCUM clears the pending IR flag
    feed(0, 1, '{255, 255, 255, 255, 5, 5, 5, 5}, 8, 1, 1);
    feed(1, 0, '{255, 255, 255, 255, 9, 9, 0, 0}, 6, 1, 1);
    drive(1, 1, 1, 1, 1, 8'd9, 1, 0);
    feed(1, 0, '{255, 255, 255, 255, 9, 9, 9, 9}, 8, 1, 1);
    check("none_valid", a_valid, 0);

    // cal_done low: strobes produce nothing
    for (int i = 0; i < 24; i++)
      drive(1, 0, (i / 6) % 2 == 0, (i / 6) % 2 == 1, 1, 8'(i * 7), 1, 0);
    check("cal_off_a", a_valid, 0); check("cal_off_b", b_valid, 0);

    // Reset mid-ACCUM while a pair is pending
    feed(1, 0, '{255, 255, 255, 255, 11, 11, 11, 11}, 8, 0, 0);
    feed(0, 1, '{255, 255, 255, 255, 22, 22, 22, 22}, 8, 0, 0);
    check("pre_rst_valid", a_valid, 1);
    feed(1, 0, '{255, 255, 255, 255, 3, 3, 0, 0}, 6, 0, 0);
    drive(0, 1, 1, 0, 1, 8'd3, 0, 0);
    check("mid_rst_valid", a_valid, 0); check("mid_rst_red", a_red, 0);
    check("mid_rst_ir", a_ir, 0);       check("mid_rst_bvalid", b_valid, 0);

    // Random LED segments, strobes, backpressure, clears and resets
    rnd_ph = PH_RED;
    for (int s = 0; s < 300; s++) begin
      int kind, len;
      kind = $urandom_range(0, 19);
      len  = $urandom_range(1, 24);
      if (kind > 2) rnd_ph = ($urandom_range(0, 3) == 0) ? rnd_ph : (rnd_ph == PH_RED ? PH_IR : PH_RED);
      for (int c = 0; c < len; c++) begin
        bit rn, cal, red, ir;
        rn  = !(kind == 2 && c == 0);
        cal = (kind != 1);
        red = (kind == 0) || (kind > 2 && rnd_ph == PH_RED) || (kind == 1);
        ir  = (kind == 0) || (kind > 2 && rnd_ph == PH_IR);
        drive(rn, cal, red, ir, $urandom_range(0, 9) < 6, 8'($urandom),
              $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ppg_channel_sampler.md
# ppg_channel_sampler

Downstream of the LED/gain calibration controller, ahead of the FIR filter. Demultiplexes the shared 8-bit photodiode ADC stream into red and IR channels using the controller's LED enables. Discards settling samples after each LED switch, averages a fixed number of samples per slot, and emits one red/IR sample pair per alternation period on a valid/ready handshake.

## Interface
Parameters:
- W, 8, ADC sample width
- SETTLE_SAMPLES, 4, ADC samples discarded after each LED phase change (1..255)
- AVG_LOG2, 2, log2 of samples averaged per slot (0..6)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low; clock clk
- adc  in  W  ADC sample from front-end
- adc_valid  in  1  one-cycle strobe, adc holds a new conversion
- led_red  in  1  red LED enable from controller
- led_ir  in  1  IR LED enable from controller
- cal_done  in  1  high while controller is in alternating mode; low forces IDLE
- ovr_clr  in  1  clears sticky overrun
- out_red  out  W  averaged red sample of current pair
- out_ir  out  W  averaged IR sample of current pair
- out_valid  out  1  pair available
- out_ready  in  1  consumer accepts pair when out_valid and out_ready both high
- overrun  out  1  sticky: completed pair dropped because previous not consumed

## Operation
- Phase decode (combinational): led_red & !led_ir → RED; led_ir & !led_red → IR; else NONE.
- Registered phase_q; phase change = phase != phase_q.
- States: IDLE, SETTLE, ACCUM, HOLD.
  - IDLE: entered on reset, cal_done=0, or phase NONE. Clears accumulator, counters, red_have, ir_have. Leaves to SETTLE when cal_done=1 and phase ∈ {RED, IR}.
  - SETTLE: counts adc_valid strobes; samples ignored. After SETTLE_SAMPLES strobes → ACCUM.
  - ACCUM: on each adc_valid, acc += adc, cnt++. On 2^AVG_LOG2-th strobe: slot result = (acc + adc) >> AVG_LOG2 (truncation), stored in red_avg or ir_avg per phase_q, corresponding have-flag set → HOLD.
  - HOLD: ignore samples until phase change.
- Phase change in SETTLE/ACCUM/HOLD: discard partial accumulation, restart SETTLE for the new phase; change to NONE → IDLE. Have-flags survive RED↔IR changes.
- Accumulator width W+AVG_LOG2; no overflow possible.
- Pair assembly: when both have-flags set, load out_red/out_ir, clear both flags.
  - out_valid=0, or out_ready=1 that cycle: load, out_valid=1.
  - out_valid=1 and out_ready=0: pair dropped, outputs unchanged, overrun=1.
- Handshake: out_valid high, outputs stable until accepted; accept clears out_valid unless a new pair loads same cycle (valid stays 1, new data).
- A slot completing for a phase whose flag is already set overwrites that average (latest wins).
- overrun cleared by ovr_clr; set has priority over clear in the same cycle.
- cal_done falling: IDLE next cycle; a pending out_valid pair remains until accepted.

## Timing
- All outputs registered. Reset values: out_red=0, out_ir=0, out_valid=0, overrun=0; state IDLE, phase_q=NONE.
- Phase change observed one cycle after LED inputs change (phase_q register); SETTLE count starts from the first adc_valid after that edge.
- Slot result and pair load: out_valid rises on the clock edge ending the cycle carrying the final ACCUM adc_valid (1-cycle latency).
- adc_valid coincident with a phase change: sample is discarded.
- Throughput: at most one pair per clock; one pair per red+IR slot in practice.

## Structure
- Shared package ppg_pkg: phase enum (PH_NONE, PH_RED, PH_IR), sampler state enum, ADC width constant W, shared with controller and FIR stage.
- Sub-module ppg_slot_accum: sample counter, accumulator, shift-average, done pulse; parameters W, AVG_LOG2; cleared by FSM restart.
- Top: phase decode, FSM, have-flags, output/handshake/overrun logic.

## Test plan
- Basic pair: cal_done=1, RED; 4 settle samples of 255 then 10,20,30,41 → red 25; IR, 4 settle then 200×4 → out_red=25, out_ir=200, out_valid 1 cycle after last strobe.
- Truncation: RED samples 1,1,1,2 → out_red=1; AVG_LOG2=0 with single sample 77 → 77.
- Mid-slot switch: RED, settle + 2 samples, switch to IR → no red result; IR then RED complete → pair from post-switch slots only.
- Backpressure: out_ready=0, two full pairs → first pair held, overrun=1, outputs unchanged; ovr_clr → overrun=0; out_ready=1 with new pair completing same cycle → valid stays 1, new data.
- NONE/cal_done: both LEDs high mid-ACCUM → IDLE, flags cleared; cal_done=0 → no output despite valid samples.
- Reset mid-ACCUM with out_valid=1: rst_n=0 one cycle → all outputs 0, IDLE next cycle.
